mac_execute_stage: RTL

- Execute stage that sits directly upstream of the DSP core's register file.
- Consumes two register operands (dataA/dataB) plus a decoded opcode and destination.
- Runs signed fixed-point multiply/multiply-accumulate into a wide accumulator.
- On STORE, produces the register-file write port (writeAddr, dataW, writeEnable) with shift-and-saturate.

---
 rtl/nanomixer_exec_pkg.sv | 43 ++++
 rtl/mac_execute_stage_sat_shift.sv | 35 +++
 rtl/mac_execute_stage.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/nanomixer_exec_pkg.sv
// Shared types and constants for the MAC execute stage.
//   exec_op_t : decoded execute opcode (values 6 and 7 are undefined and act as NOP)
//   stage_t   : per-stage pipeline record (valid, op, rd)
//   sat_max / sat_min : signed saturation limits for a given width, in 128-bit form
package nanomixer_exec_pkg;

  localparam int unsigned DEF_DATA_WIDTH    = 32;
  localparam int unsigned DEF_ACC_WIDTH     = 64;
  localparam int unsigned DEF_FRAC_BITS     = 24;
  localparam int unsigned DEF_REGADDR_WIDTH = 5;

  typedef enum logic [2:0] {
    NOP    = 3'd0,
    MUL    = 3'd1,
    MAC    = 3'd2,
    MSUB   = 3'd3,
    STORE  = 3'd4,
    CLRACC = 3'd5
  } exec_op_t;

  // Pipeline record; rd is sized for the default register-file address width.
  typedef struct packed {
    logic                         valid;
    exec_op_t                     op;
    logic [DEF_REGADDR_WIDTH-1:0] rd;
  } stage_t;

  // Largest signed value of a given width: 2^(width-1)-1.
  function automatic logic [127:0] sat_max(input int unsigned width);
    return (128'(1) << (width - 1)) - 128'(1);
  endfunction

  // Smallest signed value of a given width: -2^(width-1), two's complement in 128 bits.
  function automatic logic [127:0] sat_min(input int unsigned width);
    return ~sat_max(width);
  endfunction

  localparam logic [DEF_ACC_WIDTH-1:0]  ACC_SAT_MAX  = DEF_ACC_WIDTH'(sat_max(DEF_ACC_WIDTH));
  localparam logic [DEF_ACC_WIDTH-1:0]  ACC_SAT_MIN  = DEF_ACC_WIDTH'(sat_min(DEF_ACC_WIDTH));
  localparam logic [DEF_DATA_WIDTH-1:0] DATA_SAT_MAX = DEF_DATA_WIDTH'(sat_max(DEF_DATA_WIDTH));
  localparam logic [DEF_DATA_WIDTH-1:0] DATA_SAT_MIN = DEF_DATA_WIDTH'(sat_min(DEF_DATA_WIDTH));

endpackage

// File: rtl/mac_execute_stage_sat_shift.sv
// sat_shift: combinational arithmetic right shift followed by a signed clamp.
//   data_i   : signed input value (IN_WIDTH)
//   data_c_o : shifted value clamped to the signed OUT_WIDTH range
//   clip_c_o : high when the clamp changed the value
module sat_shift
  import nanomixer_exec_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 64,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned SHIFT     = 24
) (
  input  logic [IN_WIDTH-1:0]  data_i,
  output logic [OUT_WIDTH-1:0] data_c_o,
  output logic                 clip_c_o
);

  localparam int unsigned UPPER_WIDTH = IN_WIDTH - OUT_WIDTH + 1;

  logic signed [IN_WIDTH-1:0] shifted;
  logic [UPPER_WIDTH-1:0]     upper;

  // The result fits when every bit from the output sign bit upward is identical.
  always_comb begin
    shifted  = $signed(data_i) >>> SHIFT;
    upper    = shifted[IN_WIDTH-1:OUT_WIDTH-1];
    clip_c_o = !((&upper) || !(|upper));
    if (clip_c_o) begin
      data_c_o = shifted[IN_WIDTH-1] ? OUT_WIDTH'(sat_min(OUT_WIDTH))
                                     : OUT_WIDTH'(sat_max(OUT_WIDTH));
    end else begin
      data_c_o = shifted[OUT_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mac_execute_stage.sv
// mac_execute_stage: three-stage signed fixed-point MUL/MAC/MSUB execute unit
// feeding the register-file write port.
//   E1 registers the decoded instruction and the full-width product,
//   E2 updates the saturating accumulator (STORE samples it),
//   E3 shifts/clamps the sample and registers the write port.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   issueValid, opcode, rd     : instruction issue (opcode is exec_op_t)
//   dataA, dataB               : signed operands
//   writeAddr, dataW           : register-file write address/data (hold when idle)
//   writeEnable                : one-cycle write strobe (never for rd==0)
//   accSat                     : one-cycle pulse when a STORE result was clipped
//   satClear, satSticky        : only with MAC_EXECUTE_SAT_STICKY_EN; sticky clip flag
// REGADDR_WIDTH must match the stage record rd field width in the package.
module mac_execute_stage
  import nanomixer_exec_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned ACC_WIDTH     = DEF_ACC_WIDTH,
  parameter int unsigned FRAC_BITS     = DEF_FRAC_BITS,
  parameter int unsigned REGADDR_WIDTH = DEF_REGADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef MAC_EXECUTE_SAT_STICKY_EN
  input  logic                     satClear,
  output logic                     satSticky,
`endif
  input  logic                     issueValid,
  input  logic [2:0]               opcode,
  input  logic [REGADDR_WIDTH-1:0] rd,
  input  logic [DATA_WIDTH-1:0]    dataA,
  input  logic [DATA_WIDTH-1:0]    dataB,
  output logic [REGADDR_WIDTH-1:0] writeAddr,
  output logic [DATA_WIDTH-1:0]    dataW,
  output logic                     writeEnable,
  output logic                     accSat
);

  localparam logic [ACC_WIDTH-1:0] ACC_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));

  stage_t                         e1_q, e1_d, e2_q, e2_d;
  logic [ACC_WIDTH-1:0]           prod_q, prod_d;
  logic [ACC_WIDTH-1:0]           acc_q, acc_d;
  logic [ACC_WIDTH-1:0]           store_acc_q, store_acc_d;
  logic signed [2*DATA_WIDTH-1:0] prod_full;
  logic [ACC_WIDTH:0]             sum_ext, diff_ext;
  logic                           acc_clip_c;
  logic                           store_en_c;
  logic [DATA_WIDTH-1:0]          wb_data_c;
  logic                           wb_clip_c;

  // One extra bit of headroom; disagreement of the top two bits means overflow.
  function automatic logic [ACC_WIDTH-1:0] clamp_acc(input logic [ACC_WIDTH:0] v);
    if (v[ACC_WIDTH] != v[ACC_WIDTH-1]) begin
      return v[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
    end
    return v[ACC_WIDTH-1:0];
  endfunction

  // E1: decode (undefined opcodes become bubbles) and form the sign-extended product.
  always_comb begin
    e1_d       = '0;
    e1_d.valid = issueValid && (opcode <= 3'd5);
    e1_d.op    = e1_d.valid ? exec_op_t'(opcode) : NOP;
    e1_d.rd    = DEF_REGADDR_WIDTH'(rd);
    prod_full  = $signed(dataA) * $signed(dataB);
    prod_d     = ACC_WIDTH'(prod_full);
  end

  // E2: accumulator update; STORE snapshots the accumulator for write-back.
  always_comb begin
    sum_ext     = {acc_q[ACC_WIDTH-1], acc_q} + {prod_q[ACC_WIDTH-1], prod_q};
    diff_ext    = {acc_q[ACC_WIDTH-1], acc_q} - {prod_q[ACC_WIDTH-1], prod_q};
    acc_d       = acc_q;
    acc_clip_c  = 1'b0;
    store_acc_d = store_acc_q;
    e2_d        = e1_q;
    if (e1_q.valid) begin
      case (e1_q.op)
        MUL:    acc_d = prod_q;
        MAC: begin
          acc_d      = clamp_acc(sum_ext);
          acc_clip_c = sum_ext[ACC_WIDTH] ^ sum_ext[ACC_WIDTH-1];
        end
        MSUB: begin
          acc_d      = clamp_acc(diff_ext);
          acc_clip_c = diff_ext[ACC_WIDTH] ^ diff_ext[ACC_WIDTH-1];
        end
        CLRACC: acc_d = '0;
        STORE:  store_acc_d = acc_q;
        default: ;
      endcase
    end
  end

  // E3: shift out the fractional bits and clamp to the write-back width.
  sat_shift #(
    .IN_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH (DATA_WIDTH),
    .SHIFT     (FRAC_BITS)
  ) u_sat_shift (
    .data_i   (store_acc_q),
    .data_c_o (wb_data_c),
    .clip_c_o (wb_clip_c)
  );

  assign store_en_c = e2_q.valid && (e2_q.op == STORE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e1_q        <= '0;
      e2_q        <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      store_acc_q <= '0;
      writeAddr   <= '0;
      dataW       <= '0;
      writeEnable <= 1'b0;
      accSat      <= 1'b0;
    end else begin
      e1_q        <= e1_d;
      e2_q        <= e2_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      store_acc_q <= store_acc_d;
      writeEnable <= store_en_c && (e2_q.rd != '0);
      accSat      <= store_en_c && wb_clip_c;
      // Write port payload only moves on a real write.
      if (store_en_c && (e2_q.rd != '0)) begin
        writeAddr <= REGADDR_WIDTH'(e2_q.rd);
        dataW     <= wb_data_c;
      end
    end
  end

`ifdef MAC_EXECUTE_SAT_STICKY_EN
  logic sticky_q, sticky_d;

  // Any accumulator or write-back clamp sets the flag; a set beats a clear.
  always_comb begin
    sticky_d = sticky_q;
    if (acc_clip_c || (store_en_c && wb_clip_c)) begin
      sticky_d = 1'b1;
    end else if (satClear) begin
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign satSticky = sticky_q;
`endif

endmodule
